// File: rtl/cotm32_pkg.sv
// Shared core constants: data widths, the instruction-memory window and
// the types used by the instruction-memory arbiter.
package cotm32_pkg;

  localparam int XLEN          = 32;
  localparam int INST_WIDTH    = 32;
  localparam int INST_MEM_SIZE = 1024;

  localparam logic [XLEN-1:0] INST_MEM_START = 32'h0000_1000;
  localparam logic [XLEN-1:0] INST_MEM_END   = INST_MEM_START + 32'(INST_MEM_SIZE) - 32'd1;

  localparam int IMEM_ARB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_F,
    OWN_D
  } imem_owner_e;

endpackage

// File: rtl/imem_addr_check.sv
// Range/alignment check of one byte address against the instruction-memory
// window, plus its translation into a memory word index.
module imem_addr_check
  import cotm32_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(INST_MEM_SIZE / 4)
) (
  input  logic [XLEN-1:0]       i_addr,
  output logic                  o_legal,
  output logic [ADDR_WIDTH-1:0] o_idx
);

  logic [XLEN-1:0] w_offset;

  assign w_offset = i_addr - INST_MEM_START;

  // Legal means inside the inclusive window and word aligned.
  assign o_legal = (i_addr >= INST_MEM_START) &&
                   (i_addr <= INST_MEM_END) &&
                   (i_addr[1:0] == 2'b00);

  // Word index relative to the window base; out-of-range addresses give a
  // meaningless index, but the arbiter never strobes memory with one.
  assign o_idx = ADDR_WIDTH'(w_offset >> 2);

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port synchronous-read instruction memory between the
// fetch port (priority, read-only) and a debug/loader port (read/write).
// A starvation counter guarantees debug one grant every STARVE_LIMIT+1
// cycles under continuous fetch traffic. Responses arrive one cycle after
// the grant; illegal accesses are granted but return err=1, rdata=0.
module imem_arbiter
  import cotm32_pkg::*;
#(
  parameter int STARVE_LIMIT = IMEM_ARB_STARVE_LIMIT,
  parameter int ADDR_WIDTH   = $clog2(INST_MEM_SIZE / 4)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // fetch port
  input  logic                  i_f_req,
  input  logic [XLEN-1:0]       i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  output logic [INST_WIDTH-1:0] o_f_rdata,
  output logic                  o_f_err,
  // debug port
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [3:0]            i_d_be,
  input  logic [XLEN-1:0]       i_d_addr,
  input  logic [31:0]           i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [31:0]           o_d_rdata,
  output logic                  o_d_err,
  // memory port
  output logic                  o_mem_en,
  output logic [3:0]            o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);

  localparam int WCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] LIMIT_W = WCW'(STARVE_LIMIT);

  logic                  w_f_legal;
  logic [ADDR_WIDTH-1:0] w_f_idx;
  logic                  w_d_legal;
  logic [ADDR_WIDTH-1:0] w_d_idx;

  logic                  w_d_win;
  logic                  w_legal;
  logic                  w_f_rvalid;
  logic                  w_d_rvalid;
  logic [31:0]           w_resp_data;

  logic [WCW-1:0]        r_wait;
  imem_owner_e           r_owner;
  logic                  r_err;
  logic                  r_we;
  logic [INST_WIDTH-1:0] r_f_rdata;
  logic [31:0]           r_d_rdata;

  imem_addr_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_f_check (
    .i_addr  (i_f_addr),
    .o_legal (w_f_legal),
    .o_idx   (w_f_idx)
  );

  imem_addr_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_d_check (
    .i_addr  (i_d_addr),
    .o_legal (w_d_legal),
    .o_idx   (w_d_idx)
  );

  // Debug wins when starved, or when fetch is not asking; grants are
  // suppressed during reset so nothing is launched that reset would orphan.
  assign w_d_win = i_d_req && ((r_wait == LIMIT_W) || !i_f_req);
  assign o_d_gnt = !i_rst && w_d_win;
  assign o_f_gnt = !i_rst && i_f_req && !w_d_win;

  // Only a legal granted access touches memory; the idle port is held at 0.
  assign w_legal     = o_f_gnt ? w_f_legal : w_d_legal;
  assign o_mem_en    = (o_f_gnt || o_d_gnt) && w_legal;
  assign o_mem_addr  = !o_mem_en ? '0 : (o_f_gnt ? w_f_idx : w_d_idx);
  assign o_mem_we    = (o_mem_en && o_d_gnt && i_d_we) ? i_d_be : 4'b0000;
  assign o_mem_wdata = (o_mem_en && o_d_gnt) ? i_d_wdata : 32'd0;

  // Count consecutive cycles debug has been kept waiting, saturating at the limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait <= '0;
    end else if (i_d_req && !o_d_gnt) begin
      if (r_wait != LIMIT_W) begin
        r_wait <= r_wait + 1'b1;
      end
    end else begin
      r_wait <= '0;
    end
  end

  // Remember who owns the response due next cycle and what kind it is.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else if (o_f_gnt) begin
      r_owner <= OWN_F;
      r_err   <= !w_f_legal;
      r_we    <= 1'b0;
    end else if (o_d_gnt) begin
      r_owner <= OWN_D;
      r_err   <= !w_d_legal;
      r_we    <= i_d_we;
    end else begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end
  end

  // Memory data is only meaningful for legal reads; writes and faults return 0.
  assign w_resp_data = (r_err || r_we) ? 32'd0 : i_mem_rdata;
  assign w_f_rvalid  = (r_owner == OWN_F);
  assign w_d_rvalid  = (r_owner == OWN_D);

  // Capture each port's response data so it stays visible until its next response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_f_rvalid) begin
        r_f_rdata <= w_resp_data;
      end
      if (w_d_rvalid) begin
        r_d_rdata <= w_resp_data;
      end
    end
  end

  assign o_f_rvalid = w_f_rvalid;
  assign o_f_err    = w_f_rvalid && r_err;
  assign o_f_rdata  = w_f_rvalid ? w_resp_data : r_f_rdata;

  assign o_d_rvalid = w_d_rvalid;
  assign o_d_err    = w_d_rvalid && r_err;
  assign o_d_rdata  = w_d_rvalid ? w_resp_data : r_d_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a behavioural memory plus a reference
// model that predicts grants and responses from the arbitration rules.
module tb_imem_arbiter;
  import cotm32_pkg::*;

  localparam int AW    = $clog2(INST_MEM_SIZE / 4);
  localparam int WORDS = INST_MEM_SIZE / 4;
  localparam int LIMIT = IMEM_ARB_STARVE_LIMIT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fReq = 1'b0;
  logic [31:0]   fAddr = '0;
  logic          fGnt, fRvalid, fErr;
  logic [31:0]   fRdata;
  logic          dReq = 1'b0;
  logic          dWe = 1'b0;
  logic [3:0]    dBe = '0;
  logic [31:0]   dAddr = '0;
  logic [31:0]   dWdata = '0;
  logic          dGnt, dRvalid, dErr;
  logic [31:0]   dRdata;
  logic          memEn;
  logic [3:0]    memWe;
  logic [AW-1:0] memAddr;
  logic [31:0]   memWdata;
  logic [31:0]   memRdata = '0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       fQ[$];
  resp_t       dQ[$];
  logic [31:0] tbMem  [WORDS];
  logic [31:0] refMem [WORDS];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          modelWait = 0;
  logic        lastFGnt, lastDGnt;
  logic [31:0] heldF = '0;
  logic [31:0] heldD = '0;

  imem_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_f_req     (fReq),
    .i_f_addr    (fAddr),
    .o_f_gnt     (fGnt),
    .o_f_rvalid  (fRvalid),
    .o_f_rdata   (fRdata),
    .o_f_err     (fErr),
    .i_d_req     (dReq),
    .i_d_we      (dWe),
    .i_d_be      (dBe),
    .i_d_addr    (dAddr),
    .i_d_wdata   (dWdata),
    .o_d_gnt     (dGnt),
    .o_d_rvalid  (dRvalid),
    .o_d_rdata   (dRdata),
    .o_d_err     (dErr),
    .o_mem_en    (memEn),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .i_mem_rdata (memRdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected responses
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read, byte-writable instruction memory seen by the DUT
  always @(posedge clk) begin
    if (memEn) begin
      memRdata <= tbMem[memAddr];
      for (int b = 0; b < 4; b++) begin
        if (memWe[b]) tbMem[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
      end
    end
  end

  function automatic logic refLegal(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(INST_MEM_START);
    return (off >= 0) && (off < INST_MEM_SIZE) && ((a % 32'd4) == 0);
  endfunction

  function automatic int refIdx(input logic [31:0] a);
    return int'((a - INST_MEM_START) / 32'd4) % WORDS;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One clock cycle of stimulus: drive both ports, predict and check the
  // grants and memory strobe, then queue the responses the model expects.
  task automatic applyStimulus(input logic fr, input logic [31:0] fa,
                               input logic dr, input logic dw, input logic [3:0] db,
                               input logic [31:0] da, input logic [31:0] dd);
    logic        expF, expD, legal, any;
    int          idx;
    logic [31:0] expAddr, expWe, expWdata;
    resp_t       r;
    @(posedge clk);
    #1;
    fReq = fr; fAddr = fa; dReq = dr; dWe = dw; dBe = db; dAddr = da; dWdata = dd;
    #1;
    expD = dr && ((modelWait == LIMIT) || !fr);
    expF = fr && !expD;
    lastFGnt = fGnt;
    lastDGnt = dGnt;
    checkOutput("f_gnt", {31'd0, fGnt}, {31'd0, expF});
    checkOutput("d_gnt", {31'd0, dGnt}, {31'd0, expD});
    any   = expF || expD;
    legal = expF ? refLegal(fa) : refLegal(da);
    idx   = expF ? refIdx(fa) : refIdx(da);
    expAddr  = (any && legal) ? 32'(idx) : 32'd0;
    expWe    = (any && legal && expD && dw) ? {28'd0, db} : 32'd0;
    expWdata = (any && legal && expD) ? dd : 32'd0;
    checkOutput("mem_en", {31'd0, memEn}, {31'd0, any && legal});
    checkOutput("mem_addr", 32'(memAddr), expAddr);
    checkOutput("mem_we", {28'd0, memWe}, expWe);
    checkOutput("mem_wdata", memWdata, expWdata);
    r.due = cyc + 1;
    if (expF) begin
      r.err  = !legal;
      r.data = legal ? refMem[idx] : 32'd0;
      fQ.push_back(r);
    end
    if (expD) begin
      r.err  = !legal;
      r.data = (legal && !dw) ? refMem[idx] : 32'd0;
      if (legal && dw) begin
        for (int b = 0; b < 4; b++) begin
          if (db[b]) refMem[idx][8*b +: 8] = dd[8*b +: 8];
        end
      end
      dQ.push_back(r);
    end
    if (dr && !expD) modelWait = (modelWait >= LIMIT) ? LIMIT : modelWait + 1;
    else             modelWait = 0;
  endtask

  // Monitor: every response is matched against the head of its port's queue,
  // late/missing responses are flagged, and idle rdata must hold its value.
  always @(negedge clk) begin
    resp_t r;
    if (rst) begin
      heldF = 32'd0;
      heldD = 32'd0;
    end else begin
      if (fRvalid) begin
        if (fQ.size() == 0) begin
          checkOutput("f_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          r = fQ.pop_front();
          checkOutput("f_latency", 32'(cyc), 32'(r.due));
          checkOutput("f_err", {31'd0, fErr}, {31'd0, r.err});
          checkOutput("f_rdata", fRdata, r.data);
        end
        heldF = fRdata;
      end else begin
        if (fQ.size() != 0 && fQ[0].due <= cyc) begin
          r = fQ.pop_front();
          checkOutput("f_missing_rvalid", 32'd0, 32'd1);
        end
        checkOutput("f_rdata_hold", fRdata, heldF);
      end
      if (dRvalid) begin
        if (dQ.size() == 0) begin
          checkOutput("d_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          r = dQ.pop_front();
          checkOutput("d_latency", 32'(cyc), 32'(r.due));
          checkOutput("d_err", {31'd0, dErr}, {31'd0, r.err});
          checkOutput("d_rdata", dRdata, r.data);
        end
        heldD = dRdata;
      end else begin
        if (dQ.size() != 0 && dQ[0].due <= cyc) begin
          r = dQ.pop_front();
          checkOutput("d_missing_rvalid", 32'd0, 32'd1);
        end
        checkOutput("d_rdata_hold", dRdata, heldD);
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    logic        fp, dp, dpw;
    logic [3:0]  dpb;
    logic [31:0] fpa, dpa, dpd;
    logic [31:0] S;
    S = INST_MEM_START;

    for (int i = 0; i < WORDS; i++) begin
      tbMem[i]  = 32'hA500_0000 ^ (i * 32'h0001_0203);
      refMem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
    end

    // Reset values, and grants held off while reset is high
    fReq = 1'b1; dReq = 1'b1; fAddr = S; dAddr = S;
    #12;
    checkOutput("rst_f_gnt", {31'd0, fGnt}, 32'd0);
    checkOutput("rst_d_gnt", {31'd0, dGnt}, 32'd0);
    checkOutput("rst_mem_en", {31'd0, memEn}, 32'd0);
    checkOutput("rst_f_rvalid", {31'd0, fRvalid}, 32'd0);
    checkOutput("rst_d_rvalid", {31'd0, dRvalid}, 32'd0);
    checkOutput("rst_f_err", {31'd0, fErr}, 32'd0);
    checkOutput("rst_d_err", {31'd0, dErr}, 32'd0);
    checkOutput("rst_f_rdata", fRdata, 32'd0);
    checkOutput("rst_d_rdata", dRdata, 32'd0);
    fReq = 1'b0; dReq = 1'b0;
    @(posedge clk); #3; rst = 1'b0;

    // Fetch only: three consecutive reads
    applyStimulus(1, S + 32'h0, 0, 0, 4'h0, 32'd0, 32'd0);
    applyStimulus(1, S + 32'h4, 0, 0, 4'h0, 32'd0, 32'd0);
    applyStimulus(1, S + 32'h8, 0, 0, 4'h0, 32'd0, 32'd0);
    applyStimulus(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);

    // Debug write, fetch it back, then patch one byte
    applyStimulus(0, 32'd0, 1, 1, 4'hF, S + 32'h10, 32'hDEAD_BEEF);
    applyStimulus(1, S + 32'h10, 0, 0, 4'h0, 32'd0, 32'd0);
    applyStimulus(0, 32'd0, 1, 1, 4'h1, S + 32'h10, 32'h0000_00AA);
    applyStimulus(1, S + 32'h10, 0, 0, 4'h0, 32'd0, 32'd0);
    applyStimulus(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
    checkOutput("patched_word", fRdata, 32'hDEAD_BEAA);

    // Contention: debug expected on every fifth cycle
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, S + 32'(4 * (k % 8)), 1, 0, 4'h0, S + 32'h40, 32'd0);
      checkOutput("contention_d_gnt", {31'd0, lastDGnt}, {31'd0, (k % 5) == 4});
    end
    applyStimulus(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);

    // Faults and window edges
    applyStimulus(1, S + 32'h2, 0, 0, 4'h0, 32'd0, 32'd0);
    applyStimulus(0, 32'd0, 1, 0, 4'h0, INST_MEM_END + 32'd1, 32'd0);
    applyStimulus(0, 32'd0, 1, 1, 4'hF, INST_MEM_END + 32'd1, 32'h1234_5678);
    applyStimulus(0, 32'd0, 1, 1, 4'hF, S - 32'd4, 32'h1234_5678);
    applyStimulus(1, INST_MEM_END - 32'd3, 0, 0, 4'h0, 32'd0, 32'd0);
    applyStimulus(0, 32'd0, 1, 0, 4'h0, S, 32'd0);
    applyStimulus(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);

    // Reset asserted in the cycle of a fetch grant
    @(posedge clk); #1;
    fReq = 1'b1; fAddr = S + 32'h20;
    #1;
    checkOutput("pre_reset_f_gnt", {31'd0, fGnt}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("in_reset_f_gnt", {31'd0, fGnt}, 32'd0);
    modelWait = 0;
    fReq = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    applyStimulus(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
    applyStimulus(1, S + 32'h24, 0, 0, 4'h0, 32'd0, 32'd0);

    // Randomised traffic; requests are held until granted or withdrawn
    fp = 0; dp = 0; fpa = '0; dpa = '0; dpd = '0; dpw = 0; dpb = '0;
    for (int n = 0; n < 500; n++) begin
      if (!fp && $urandom_range(0, 9) < 6) begin
        fp = 1; fpa = randAddr();
      end
      if (!dp && $urandom_range(0, 9) < 4) begin
        dp = 1; dpa = randAddr(); dpw = 1'($urandom_range(0, 1));
        dpb = 4'($urandom_range(0, 15)); dpd = $urandom;
      end
      if (fp && $urandom_range(0, 19) == 0) fp = 0;
      if (dp && $urandom_range(0, 19) == 0) dp = 0;
      applyStimulus(fp, fpa, dp, dpw, dpb, dpa, dpd);
      if (lastFGnt) fp = 0;
      if (lastDGnt) dp = 0;
    end

    for (int n = 0; n < 3; n++) applyStimulus(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
    checkOutput("f_queue_drained", 32'(fQ.size()), 32'd0);
    checkOutput("d_queue_drained", 32'(dQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [31:0] randAddr();
    int sel;
    sel = $urandom_range(0, 19);
    case (sel)
      0:       return INST_MEM_START - 32'd4;
      1:       return INST_MEM_END + 32'd1;
      2:       return INST_MEM_START + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      3:       return INST_MEM_END - 32'd3;
      default: return INST_MEM_START + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer for a single-port, synchronous-read instruction memory. It shares the memory between the core fetch port (read-only) and a debug/loader port (read/write) so programs can be loaded or patched at run time. The fetch port has priority, and a starvation counter bounds how long the debug port can wait. It sits between the fetch stage and the instruction memory array and also checks address range and alignment.

## Interface
Parameters:
- `STARVE_LIMIT`, default `IMEM_ARB_STARVE_LIMIT` (4): consecutive denied debug cycles after which debug wins; legal range ≥1.
- `ADDR_WIDTH`, default `$clog2(INST_MEM_SIZE/4)`: memory word-index width.

Ports:
- Clock/reset decided: one clock; reset is asynchronous and active-high.
- `i_clk  in  1`: clock.
- `i_rst  in  1`: asynchronous, active-high reset.
- `i_f_req  in  1`: fetch request; held until granted.
- `i_f_addr  in  XLEN`: fetch byte address.
- `o_f_gnt  out  1`: fetch grant (combinational).
- `o_f_rvalid  out  1`: fetch response valid.
- `o_f_rdata  out  INST_WIDTH`: fetched instruction.
- `o_f_err  out  1`: fetch access fault; qualified by `o_f_rvalid`.
- `i_d_req  in  1`: debug request; held until granted.
- `i_d_we  in  1`: debug write (1) or read (0).
- `i_d_be  in  4`: debug write byte enables.
- `i_d_addr  in  XLEN`: debug byte address.
- `i_d_wdata  in  32`: debug write data.
- `o_d_gnt  out  1`: debug grant (combinational).
- `o_d_rvalid  out  1`: debug response valid; also signals write acknowledge.
- `o_d_rdata  out  32`: debug read data.
- `o_d_err  out  1`: debug access fault.
- `o_mem_en  out  1`: memory access strobe.
- `o_mem_we  out  4`: memory byte write enables.
- `o_mem_addr  out  ADDR_WIDTH`: memory word index.
- `o_mem_wdata  out  32`: memory write data.
- `i_mem_rdata  in  32`: memory read data, valid the cycle after `o_mem_en`.

## Operation
- **Address check (per port):** an address is legal when it is in [`INST_MEM_START`, `INST_MEM_END`] and `addr[1:0]==0`.
- **Word index:** (`addr - INST_MEM_START`) >> 2, truncated to `ADDR_WIDTH`.
- **Arbitration:** one grant per cycle. Debug wins if `i_d_req` is high and `wait_cnt == STARVE_LIMIT`. Otherwise fetch wins if `i_f_req` is high. Otherwise debug wins if `i_d_req` is high.
- **`wait_cnt`:**
  - Increments, saturating at `STARVE_LIMIT`, on each cycle with `i_d_req && !o_d_gnt`.
  - Clears on a debug grant, or on any cycle where `i_d_req` is low.
- **Legal granted access:**
  - `o_mem_en=1`.
  - `o_mem_we = i_d_we ? i_d_be : 0` for debug; always 0 for fetch.
  - `o_mem_addr` and `o_mem_wdata` driven from the winning port.
- **Illegal granted access:** the grant is still given and the request is consumed. `o_mem_en=0`, no memory side effect; the response carries `err=1` and `rdata=0`.
- **Response tracking:** registers hold the owner (`OWN_NONE`/`OWN_F`/`OWN_D`), the error flag and the write flag for the cycle after a grant.
- **Response data:**
  - `o_*_rdata` is taken from `i_mem_rdata` for legal reads.
  - Data is 0 for writes and faults.
  - Data is held in registers until the next response to that port.
- **Idle memory port:** when `o_mem_en=0`, `o_mem_addr`, `o_mem_wdata` and `o_mem_we` are driven 0.

## Timing
- **Grant:** combinational, in the same cycle as the request. Both grants are forced to 0 while `i_rst` is high.
- **Latency:** response exactly 1 cycle after grant; `o_*_rvalid` is a single-cycle pulse. Back-to-back grants give one response per cycle with no bubbles.
- **Throughput:** 1 access per cycle total.
- **Simultaneous requests:** fetch wins unless the starvation condition holds. With both requesters continuously requesting, debug gets exactly 1 grant every `STARVE_LIMIT+1` cycles.
- **Reset values:** `o_f_rvalid`, `o_d_rvalid`, `o_f_err`, `o_d_err`, `o_f_rdata`, `o_d_rdata` = 0; `wait_cnt` = 0; owner = `OWN_NONE`. Memory outputs are 0 because no grant is given.
- **Reset mid-operation:** an access granted in the cycle reset asserts produces no response after reset releases. A memory write that was already strobed on the clock edge is not undone.
- **Request withdrawal:** dropping a request before it is granted is legal and has no effect; dropping it after grant does not cancel the response.

## Structure
- **`cotm32_pkg`:** add `IMEM_ARB_STARVE_LIMIT` and `typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} imem_owner_e`. `INST_MEM_START`, `INST_MEM_END`, `INST_MEM_SIZE`, `XLEN` and `INST_WIDTH` already exist there.
- **Sub-module `imem_addr_check`:** combinational. Inputs are the address; outputs are `legal` and the word index. It is instantiated once per port.
- **Arbiter body:** grant logic, `wait_cnt`, and the response registers.

## Test plan
- **Fetch only:** fetch reads of `INST_MEM_START+0x0`, `+0x4`, `+0x8` on consecutive cycles -> grants in the same cycles; `o_f_rvalid` on cycles 1–3 with the preloaded words, in order.
- **Debug write then fetch:** debug write `0xDEADBEEF`, `be=4'b1111` at `INST_MEM_START+0x10`, then fetch of the same address -> `o_d_rvalid` with `o_d_rdata=0`; fetch returns `0xDEADBEEF`. A later write of `0x000000AA` with `be=4'b0001` -> fetch returns `0xDEADBEAA`.
- **Contention:** both ports request continuously for 20 cycles with `STARVE_LIMIT=4` -> debug granted on cycles 4, 9, 14, 19; fetch on all other cycles; `wait_cnt` never exceeds 4.
- **Faults:** fetch at `INST_MEM_START+0x2` and debug read at `INST_MEM_END+1` -> both granted, `o_mem_en=0`; next cycle `err=1`, `rdata=0`; memory contents unchanged.
- **Reset mid-operation:** assert `i_rst` in the cycle of a fetch grant -> `o_f_rvalid` stays 0 after release; first post-reset fetch has normal 1-cycle latency.
